// File: rtl/dac_spi_out.sv
// dac_spi_out: mode-0 SPI master transmitter for the external DAC and for
// FPGA-to-FPGA loopback. It sends one or two 16-bit words MSB-first inside one
// chip-select frame. Every SPI level is held for HALF_PERIOD system clocks, so
// the receiver's three-sample stability filter always sees settled levels.
module dac_spi_out #(
    parameter int SENDWORDS   = 2,
    parameter int HALF_PERIOD = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_SPI_CS,
    output logic        o_SPI_clock,
    output logic        o_SPI_data
);

    localparam int NBITS = 16 * SENDWORDS;
    localparam int HP_W  = $clog2(HALF_PERIOD);
    localparam int BC_W  = $clog2(32) + 1;

    localparam logic [HP_W-1:0] HP_RELOAD = HP_W'(HALF_PERIOD - 1);
    localparam logic [HP_W-1:0] HP_ZERO   = {HP_W{1'b0}};
    localparam logic [BC_W-1:0] BC_LOAD   = BC_W'(NBITS);
    localparam logic [BC_W-1:0] BC_ZERO   = {BC_W{1'b0}};
    localparam logic [BC_W-1:0] BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};

    // Reject illegal parameterisations at elaboration time.
    generate
        if (HALF_PERIOD < 4) begin : g_bad_half_period
            $error("dac_spi_out: HALF_PERIOD must be 4 or more");
        end
        if ((SENDWORDS != 1) && (SENDWORDS != 2)) begin : g_bad_sendwords
            $error("dac_spi_out: SENDWORDS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SCK_HIGH = 3'd2,
        ST_SCK_LOW  = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [HP_W-1:0]   hp_cnt_r;
    logic [HP_W-1:0]   hp_cnt_nxt_s;
    logic [BC_W-1:0]   bits_left_r;
    logic [BC_W-1:0]   bits_left_nxt_s;
    logic [31:0]       shift_r;
    logic [31:0]       shift_nxt_s;
    logic [31:0]       load_word_s;
    logic              hp_zero_s;
    logic              cs_r;
    logic              cs_nxt_s;
    logic              sck_r;
    logic              sck_nxt_s;
    logic              mosi_r;
    logic              mosi_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              done_r;
    logic              done_nxt_s;

    // Frame image captured on start: word0 in the top half, word1 (or zeros) below.
    always_comb begin
        load_word_s = 32'h0000_0000;
        if (SENDWORDS == 2) begin
            load_word_s = {i_data0, i_data1};
        end else begin
            load_word_s = {i_data0, 16'h0000};
        end
    end

    assign hp_zero_s = (hp_cnt_r == HP_ZERO);

    // Next-state and next-output logic; every level change happens only on a
    // half-period boundary so CS and SCK never move on the same edge.
    always_comb begin
        state_nxt_s     = state_r;
        hp_cnt_nxt_s    = hp_cnt_r;
        bits_left_nxt_s = bits_left_r;
        shift_nxt_s     = shift_r;
        cs_nxt_s        = cs_r;
        sck_nxt_s       = sck_r;
        mosi_nxt_s      = mosi_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cs_nxt_s   = 1'b1;
                sck_nxt_s  = 1'b0;
                mosi_nxt_s = 1'b0;
                busy_nxt_s = 1'b0;
                // A start is ignored while the done pulse is still showing.
                if (i_start && !done_r) begin
                    shift_nxt_s     = load_word_s;
                    bits_left_nxt_s = BC_LOAD;
                    hp_cnt_nxt_s    = HP_RELOAD;
                    cs_nxt_s        = 1'b0;
                    mosi_nxt_s      = load_word_s[31];
                    busy_nxt_s      = 1'b1;
                    state_nxt_s     = ST_SETUP;
                end else begin
                    hp_cnt_nxt_s    = HP_ZERO;
                    bits_left_nxt_s = BC_ZERO;
                end
            end

            ST_SETUP: begin
                // CS setup time before the first rising SCK.
                if (hp_zero_s) begin
                    sck_nxt_s    = 1'b1;
                    hp_cnt_nxt_s = HP_RELOAD;
                    state_nxt_s  = ST_SCK_HIGH;
                end else begin
                    hp_cnt_nxt_s = hp_cnt_r - {{(HP_W-1){1'b0}}, 1'b1};
                end
            end

            ST_SCK_HIGH: begin
                // Falling SCK: retire the current bit and present the next one.
                if (hp_zero_s) begin
                    sck_nxt_s       = 1'b0;
                    hp_cnt_nxt_s    = HP_RELOAD;
                    shift_nxt_s     = shift_r << 1'b1;
                    bits_left_nxt_s = bits_left_r - BC_ONE;
                    if (bits_left_r > BC_ONE) begin
                        mosi_nxt_s = shift_r[30];
                    end else begin
                        mosi_nxt_s = 1'b0;
                    end
                    state_nxt_s     = ST_SCK_LOW;
                end else begin
                    hp_cnt_nxt_s = hp_cnt_r - {{(HP_W-1){1'b0}}, 1'b1};
                end
            end

            ST_SCK_LOW: begin
                // After the final bit this low phase doubles as CS hold time.
                if (hp_zero_s) begin
                    hp_cnt_nxt_s = HP_RELOAD;
                    if (bits_left_r != BC_ZERO) begin
                        sck_nxt_s   = 1'b1;
                        state_nxt_s = ST_SCK_HIGH;
                    end else begin
                        cs_nxt_s    = 1'b1;
                        state_nxt_s = ST_GAP;
                    end
                end else begin
                    hp_cnt_nxt_s = hp_cnt_r - {{(HP_W-1){1'b0}}, 1'b1};
                end
            end

            ST_GAP: begin
                // Minimum CS-high gap before the frame is reported complete.
                if (hp_zero_s) begin
                    done_nxt_s   = 1'b1;
                    busy_nxt_s   = 1'b0;
                    hp_cnt_nxt_s = HP_ZERO;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    hp_cnt_nxt_s = hp_cnt_r - {{(HP_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                hp_cnt_nxt_s    = HP_ZERO;
                bits_left_nxt_s = BC_ZERO;
                cs_nxt_s        = 1'b1;
                sck_nxt_s       = 1'b0;
                mosi_nxt_s      = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            hp_cnt_r    <= HP_ZERO;
            bits_left_r <= BC_ZERO;
            shift_r     <= 32'h0000_0000;
            cs_r        <= 1'b1;
            sck_r       <= 1'b0;
            mosi_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hp_cnt_r    <= hp_cnt_nxt_s;
            bits_left_r <= bits_left_nxt_s;
            shift_r     <= shift_nxt_s;
            cs_r        <= cs_nxt_s;
            sck_r       <= sck_nxt_s;
            mosi_r      <= mosi_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_SPI_CS    = cs_r;
    assign o_SPI_clock = sck_r;
    assign o_SPI_data  = mosi_r;

endmodule

// File: tb/tb_dac_spi_out.sv
// Bench for dac_spi_out: two instances (default 2 words / half period 4, and
// 1 word / half period 6). Drivers push expected frames into a scoreboard
// queue; an SPI slave monitor rebuilds each frame and checks it on o_done.
module tb_dac_spi_out;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    logic st0 = 1'b0, st1 = 1'b0;
    logic [15:0] d00 = 16'h0, d01 = 16'h0, d10 = 16'h0, d11 = 16'h0;
    logic busy0, done0, cs0, sck0, mosi0;
    logic busy1, done1, cs1, sck1, mosi1;

    always #5 i_clock = ~i_clock;

    dac_spi_out #(.SENDWORDS(2), .HALF_PERIOD(4)) u_dut0 (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(st0),
        .i_data0(d00), .i_data1(d01), .o_busy(busy0), .o_done(done0),
        .o_SPI_CS(cs0), .o_SPI_clock(sck0), .o_SPI_data(mosi0));

    dac_spi_out #(.SENDWORDS(1), .HALF_PERIOD(6)) u_dut1 (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(st1),
        .i_data0(d10), .i_data1(d11), .o_busy(busy1), .o_done(done1),
        .o_SPI_CS(cs1), .o_SPI_clock(sck1), .o_SPI_data(mosi1));

    logic cs_a[2], sck_a[2], mosi_a[2], busy_a[2], done_a[2];
    assign cs_a[0] = cs0;     assign cs_a[1] = cs1;
    assign sck_a[0] = sck0;   assign sck_a[1] = sck1;
    assign mosi_a[0] = mosi0; assign mosi_a[1] = mosi1;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1;
    assign done_a[0] = done0; assign done_a[1] = done1;

    typedef struct {
        int          dut;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic rst_seen = 1'b1;
    bit gap_chk = 1'b0;

    // monitor state per instance
    logic        p_cs[2], p_sck[2], p_mosi[2];
    logic [31:0] rx[2];
    int rise_cnt[2]     = '{0, 0};
    int fall_cyc[2]     = '{0, 0};
    int cs_rise[2]      = '{0, 0};
    int last_rise[2]    = '{-1000, -1000};
    int last_mchg[2]    = '{-1000, -1000};
    int last_done[2]    = '{-1000, -1000};
    int done_total[2]   = '{0, 0};
    int mosi_hi[2]      = '{0, 0};
    int mosi_hi_last[2] = '{0, 0};

    function automatic int hp_of(input int d);
        return (d == 0) ? 4 : 6;
    endfunction

    function automatic int nb_of(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge i_clock) begin
        cyc      <= cyc + 1;
        rst_seen <= i_reset;
    end

    // SPI slave model, protocol checker and scoreboard consumer.
    always @(negedge i_clock) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_seen) begin
                rise_cnt[d] = 0;
                rx[d]       = 32'h0;
                mosi_hi[d]  = 0;
            end else begin
                if (cs_a[d] != p_cs[d] || sck_a[d] != p_sck[d])
                    chk("cs_sck_same_edge", longint'(cs_a[d] != p_cs[d] && sck_a[d] != p_sck[d]), 0);
                if (cs_a[d])
                    chk("sck_low_while_cs_high", longint'(sck_a[d]), 0);
                if (p_cs[d] && !cs_a[d]) begin
                    fall_cyc[d] = cyc;
                    rise_cnt[d] = 0;
                    rx[d]       = 32'h0;
                    mosi_hi[d]  = 0;
                    if (gap_chk && d == 0)
                        chk("restart_gap", cyc - last_done[d], 2);
                end
                if (!p_cs[d] && cs_a[d])
                    cs_rise[d] = cyc;
                if (!p_sck[d] && sck_a[d]) begin
                    if (!cs_a[d]) begin
                        rx[d] = {rx[d][30:0], mosi_a[d]};
                        rise_cnt[d]++;
                    end
                    last_rise[d] = cyc;
                    chk("mosi_setup", longint'(cyc - last_mchg[d] >= hp_of(d)), 1);
                end
                if (mosi_a[d] != p_mosi[d]) begin
                    last_mchg[d] = cyc;
                    chk("mosi_hold", longint'(cyc - last_rise[d] >= hp_of(d)), 1);
                end
                if (!cs_a[d] && mosi_a[d])
                    mosi_hi[d]++;
                if (done_a[d]) begin
                    last_done[d] = cyc;
                    done_total[d]++;
                    mosi_hi_last[d] = mosi_hi[d];
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("frame_dut", d, e.dut);
                        chk("frame_data", rx[d], e.data);
                        chk("rise_count", rise_cnt[d], nb_of(d));
                        chk("done_latency", cyc - fall_cyc[d], hp_of(d) * (2 + 2 * nb_of(d)));
                        chk("cs_low_cycles", cs_rise[d] - fall_cyc[d], hp_of(d) * (2 * nb_of(d) + 1));
                    end
                end
            end
            p_cs[d]   = cs_a[d];
            p_sck[d]  = sck_a[d];
            p_mosi[d] = mosi_a[d];
        end
    end

    task automatic wait_idle(input int d);
        for (int n = 0; busy_a[d] || done_a[d]; n++) begin
            if (n >= 3000) begin
                chk("idle_timeout", 1, 0);
                break;
            end
            @(negedge i_clock); #1;
        end
    endtask

    task automatic wait_done(input int d, input int target);
        for (int n = 0; done_total[d] < target; n++) begin
            if (n >= 3000) begin
                chk("done_timeout", done_total[d], target);
                break;
            end
            @(negedge i_clock); #1;
        end
    endtask

    task automatic send(input int d, input logic [15:0] a, input logic [15:0] b, input bit scramble);
        int target;
        exp_t e;
        wait_idle(d);
        target = done_total[d] + 1;
        e.dut  = d;
        e.data = (d == 0) ? {a, b} : {16'h0000, a};
        q.push_back(e);
        if (d == 0) begin d00 = a; d01 = b; st0 = 1'b1; end
        else begin d10 = a; d11 = b; st1 = 1'b1; end
        @(posedge i_clock); #1;
        st0 = 1'b0;
        st1 = 1'b0;
        if (scramble) begin
            if (d == 0) begin d00 = 16'hFFFF; d01 = 16'h0000; end
            else begin d10 = 16'hFFFF; end
        end
        wait_done(d, target);
    endtask

    initial begin
        int base;
        exp_t e;
        logic [15:0] ra, rb;

        repeat (3) @(negedge i_clock);
        #1;
        i_reset = 1'b0;
        chk("reset_state0", {cs0, sck0, mosi0, busy0, done0}, 5'b10000);
        chk("reset_state1", {cs1, sck1, mosi1, busy1, done1}, 5'b10000);

        // Directed frame; data changed right after the start edge.
        send(0, 16'hA5C3, 16'h1234, 1'b1);

        // Start held high: three back-to-back frames.
        wait_idle(0);
        ra = 16'($urandom);
        rb = 16'($urandom);
        base = done_total[0];
        e.dut = 0;
        e.data = {ra, rb};
        repeat (3) q.push_back(e);
        d00 = ra; d01 = rb; st0 = 1'b1;
        wait_done(0, base + 1);
        gap_chk = 1'b1;
        wait_done(0, base + 3);
        st0 = 1'b0;
        gap_chk = 1'b0;

        // Reset in the middle of word0 bit 10.
        wait_idle(0);
        e.dut = 0;
        e.data = {16'hC0DE, 16'hBEEF};
        q.push_back(e);
        d00 = 16'hC0DE; d01 = 16'hBEEF; st0 = 1'b1;
        @(posedge i_clock); #1;
        st0 = 1'b0;
        for (int n = 0; rise_cnt[0] < 6; n++) begin
            if (n >= 1000) begin
                chk("rise6_timeout", rise_cnt[0], 6);
                break;
            end
            @(negedge i_clock); #1;
        end
        base = done_total[0];
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        chk("reset_midframe", {cs0, sck0, mosi0, busy0, done0}, 5'b10000);
        void'(q.pop_back());
        repeat (300) @(negedge i_clock);
        #1;
        chk("no_done_after_abort", done_total[0], base);

        // Fresh frame after the abort, then random frames.
        send(0, 16'hA5C3, 16'h1234, 1'b0);
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge i_clock);
            send(0, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Single-word instance.
        send(1, 16'h8001, 16'hFFFF, 1'b0);
        chk("mosi_high_cycles_8001", mosi_hi_last[1], 4 * 6);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge i_clock);
            send(1, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (20) @(negedge i_clock);
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
